vedic_mult_seq: RTL and testbench
=================================

Name: vedic_mult_seq

Overview:
Parametrised, multi-cycle Vedic (Urdhva-Tiryagbhyam) multiplier. It is the sequential successor to the team's fixed-width combinational Vedic multipliers.
- Operands are split into K = WIDTH/CHUNK chunks.
- One CHUNK x CHUNK partial product is computed per cycle and accumulated at the correct shift.
- Uses valid/ready handshakes on both sides. Intended for area-constrained datapaths where one shared small multiplier replaces a full array.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK and >= CHUNK.
CHUNK, 4, width of the combinational Vedic kernel; K = WIDTH/CHUNK; partial products per operation = K*K.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operands a/b presented.
in_ready  output  1  block can accept operands (high only in IDLE).
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
out_valid  output  1  product valid.
out_ready  input  1  consumer accepts product.
product  output  2*WIDTH  result, stable while out_valid.
busy  output  1  high in CALC or DONE.

Behaviour:
- Clock/reset: one clock (clk). Reset (rst_n) is synchronous and active-low.
- Reset (rst_n=0 at an edge): state=IDLE, in_ready=1 after the edge, out_valid=0, busy=0, product=0, accumulator=0, count=0.
- Reset mid-operation: the operation is discarded and no product is emitted.
- States:
  - IDLE: in_ready=1. If in_valid at an edge: capture a, b; clear accumulator; count=0; go to CALC.
  - CALC: each edge adds pp(count) to the accumulator and increments count. On the edge where count==K*K-1, the final sum is written to product and the state goes to DONE.
  - DONE: out_valid=1. If out_ready at an edge, go to IDLE.
- Partial-product order: count maps to i = count mod K (chunk of a) and j = count div K (chunk of b). pp = a_chunk[i] * b_chunk[j], zero-extended to 2*WIDTH and shifted left by (i+j)*CHUNK.
- Accumulator is 2*WIDTH bits; the final value always fits, so no overflow handling is needed.
- Latency: acceptance edge T. out_valid is high after edge T+K*K (16 cycles for the defaults).
- Throughput: at most one operation per K*K+2 cycles. There is no same-cycle IDLE bypass: in_ready rises the cycle after the DONE handshake.
- in_valid outside IDLE is ignored; a and b are don't-care when not accepted.
- Backpressure: product and out_valid hold indefinitely while out_ready=0.
- out_ready outside DONE is ignored.
- busy = (state != IDLE).

Optional Feature:
Macro VEDIC_SIGNED_EN.
- Defined:
  - Adds input port op_signed (1 bit), captured with a and b.
  - When op_signed=1, the operands are two's complement. Magnitudes are formed at capture; -2^(WIDTH-1) has a magnitude that fits in WIDTH unsigned bits.
  - The result sign is the XOR of the operand MSBs.
  - The final product is negated on the last CALC edge when the sign is 1. Latency is unchanged.
  - op_signed=0 gives unsigned behaviour.
- Undefined: op_signed does not exist; unsigned only.

Decomposition:
- Package vedic_pkg: state enum type (IDLE, CALC, DONE) and a function computing the count width, clog2(K*K).
- Sub-module vedic_chunk_mult: combinational CHUNK x CHUNK Urdhva-Tiryagbhyam kernel, parametrised on CHUNK, output 2*CHUNK bits.
- Instantiated once in vedic_mult_seq.

Test Plan:
- Defaults; a=16'h1234, b=16'h5678, out_ready=1 -> product=32'h06260060; out_valid rises exactly 16 cycles after the acceptance edge and lasts 1 cycle.
- a=16'hFFFF, b=16'hFFFF, hold out_ready=0 for 5 cycles -> product=32'hFFFE0001, stable with out_valid=1 throughout; in_ready=0 until the cycle after the handshake.
- Start a=16'h00FF, b=16'h0101, assert rst_n=0 at cycle 7 of CALC -> next cycle out_valid=0, product=0, in_ready=1; a following op a=3, b=5 -> product=15.
- WIDTH=8, CHUNK=2; a=8'hFF, b=8'hFF -> product=16'hFE01 after 16 cycles. Also a=0 with any b -> product=0.
- VEDIC_SIGNED_EN, op_signed=1:
  - 16'hFFFD x 16'h0005 -> 32'hFFFFFFF1.
  - 16'h8000 x 16'h8000 -> 32'h40000000.
  - With op_signed=0, 16'hFFFF x 16'h0002 -> 32'h0001FFFE.
- in_valid held high continuously across 3 ops with out_ready=1 -> exactly 3 products emitted, each 18 cycles apart, no operand captured during CALC or DONE.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared types and sizing helpers for the sequential Vedic multiplier.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the partial-product counter for K chunks (never below 1 bit).
    function automatic int count_width(input int k);
        int n;
        n = k * k;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vedic_chunk_mult.sv
// Combinational CHUNK x CHUNK Urdhva-Tiryagbhyam kernel: column-wise crosswise sums with ripple carry.
module vedic_chunk_mult #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]   a_i,
    input  logic [CHUNK-1:0]   b_i,
    output logic [2*CHUNK-1:0] p_o
);

    localparam int SW = 2 * CHUNK + 2;

    logic [SW-1:0] col_sum_s;
    logic [SW-1:0] carry_s;

    // Each column c sums every bit pair with i+j==c plus the carry from column c-1.
    always_comb begin
        p_o       = '0;
        carry_s   = '0;
        col_sum_s = '0;
        for (int c = 0; c < 2 * CHUNK - 1; c++) begin
            col_sum_s = carry_s;
            for (int i = 0; i < CHUNK; i++) begin
                for (int j = 0; j < CHUNK; j++) begin
                    col_sum_s = col_sum_s + ((i + j == c) ? {{(SW-1){1'b0}}, a_i[i] & b_i[j]}
                                                          : {SW{1'b0}});
                end
            end
            p_o[c]  = col_sum_s[0];
            carry_s = {1'b0, col_sum_s[SW-1:1]};
        end
        p_o[2*CHUNK-1] = carry_s[0];
    end

endmodule

// File: rtl/vedic_mult_seq.sv
// Sequential Vedic multiplier: one CHUNK x CHUNK partial product per cycle, valid/ready on both sides.
// Optional signed operation is enabled with the VEDIC_SIGNED_EN macro (adds port op_signed).
module vedic_mult_seq
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef VEDIC_SIGNED_EN
    input  logic               op_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int K    = WIDTH / CHUNK;
    localparam int NPP  = K * K;
    localparam int CNTW = count_width(K);
    localparam int IW   = (K > 1) ? $clog2(K) : 1;
    localparam int PW   = 2 * WIDTH;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NPP - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(K - 1);

    state_t            state_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              sign_q;
    logic [PW-1:0]     acc_q, product_q;
    logic [CNTW-1:0]   count_q;
    logic [IW-1:0]     i_q, j_q;
    logic              out_valid_q, in_ready_q, busy_q;

    logic [WIDTH-1:0]  a_cap_s, b_cap_s;
    logic              sign_cap_s;
    logic [CHUNK-1:0]  a_chunk_s, b_chunk_s;
    logic [2*CHUNK-1:0] pp_s;
    logic [PW-1:0]     pp_shift_s;
    int                shamt_s;
    logic [PW-1:0]     acc_d, product_d;
    logic [CNTW-1:0]   count_d;
    logic [IW-1:0]     i_d, j_d;

    // Operand capture: signed mode stores magnitudes and remembers the result sign.
    always_comb begin
`ifdef VEDIC_SIGNED_EN
        if (op_signed) begin
            a_cap_s    = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
            b_cap_s    = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;
            sign_cap_s = a[WIDTH-1] ^ b[WIDTH-1];
        end else begin
            a_cap_s    = a;
            b_cap_s    = b;
            sign_cap_s = 1'b0;
        end
`else
        a_cap_s    = a;
        b_cap_s    = b;
        sign_cap_s = 1'b0;
`endif
    end

    // Chunk selection and accumulation; i walks a-chunks fastest, j walks b-chunks.
    always_comb begin
        a_chunk_s  = a_q[int'(i_q)*CHUNK +: CHUNK];
        b_chunk_s  = b_q[int'(j_q)*CHUNK +: CHUNK];
        shamt_s    = (int'(i_q) + int'(j_q)) * CHUNK;
        pp_shift_s = PW'(pp_s) << shamt_s;
        acc_d      = acc_q + pp_shift_s;
        product_d  = sign_q ? ({PW{1'b0}} - acc_d) : acc_d;
        count_d    = count_q + 1'b1;
        if (i_q == IDX_LAST) begin
            i_d = '0;
            j_d = j_q + 1'b1;
        end else begin
            i_d = i_q + 1'b1;
            j_d = j_q;
        end
    end

    vedic_chunk_mult #(.CHUNK(CHUNK)) u_kernel (
        .a_i (a_chunk_s),
        .b_i (b_chunk_s),
        .p_o (pp_s)
    );

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            i_q         <= '0;
            j_q         <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_cap_s;
                        b_q        <= b_cap_s;
                        sign_q     <= sign_cap_s;
                        acc_q      <= '0;
                        count_q    <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    count_q <= count_d;
                    i_q     <= i_d;
                    j_q     <= j_d;
                    if (count_q == CNT_LAST) begin
                        product_q   <= product_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Scoreboard bench for vedic_mult_seq: default 16/4 instance plus an 8/2 instance.
module tb_vedic_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] a, b;
    logic [31:0] product;
`ifdef VEDIC_SIGNED_EN
    logic        op_signed, op_signed8;
`endif
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int last_acc = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp8_q[$];
    int out_cyc[$];

    vedic_mult_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef VEDIC_SIGNED_EN
        .op_signed(op_signed),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    vedic_mult_seq #(.WIDTH(8), .CHUNK(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8),
`ifdef VEDIC_SIGNED_EN
        .op_signed(op_signed8),
`endif
        .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Monitors: pop the expected product on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_product: actual %0h required none", product);
            end else begin
                chk("product", 64'(product), 64'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (exp8_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_product8: actual %0h required none", product8);
            end else begin
                chk("product8", 64'(product8), 64'(exp8_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic [31:0] e,
                         input bit track, input bit keep);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL issue_timeout: in_ready actual 0 required 1");
        end
        a = va; b = vb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (track) exp_q.push_back(e);
        if (keep) begin a = 16'hFFFF; b = 16'hFFFF; end
        else in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] e);
        int n;
        n = 0;
        while (!in_ready8 && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready8) begin
            total_cnt++;
            $display("FAIL issue8_timeout: in_ready actual 0 required 1");
        end
        a8 = va; b8 = vb; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        exp8_q.push_back(e);
        in_valid8 = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_valid8(output int n);
        n = 0;
        while (!out_valid8 && n < 40) begin @(posedge clk); #1; n++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc_c[3];
        bit seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0;
`ifdef VEDIC_SIGNED_EN
        op_signed = 1'b0; op_signed8 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_in_ready8", 64'(in_ready8), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic operation and latency
        issue(16'h1234, 16'h5678, 32'h06260060, 1'b1, 1'b0);
        chk("busy_calc", 64'(busy), 64'd1);
        wait_valid(n);
        chk("latency", 64'(n), 64'd16);
        @(posedge clk); #1;
        chk("valid_one_cycle", 64'(out_valid), 64'd0);
        chk("in_ready_after_hs", 64'(in_ready), 64'd1);

        // Backpressure
        out_ready = 1'b0;
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, 1'b0);
        wait_valid(n);
        for (int k = 0; k < 5; k++) begin
            chk("bp_product", 64'(product), 64'h00000000FFFE0001);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_out_valid_after", 64'(out_valid), 64'd0);
        chk("bp_busy_after", 64'(busy), 64'd0);

        // Reset in the middle of CALC discards the operation
        issue(16'h00FF, 16'h0101, 32'h0000FFFF, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_product", 64'(product), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        chk("no_product_after_rst", 64'(seen), 64'd0);
        issue(16'h0003, 16'h0005, 32'd15, 1'b1, 1'b0);
        issue(16'hABCD, 16'h0001, 32'h0000ABCD, 1'b1, 1'b0);
        issue(16'h0000, 16'h1234, 32'h00000000, 1'b1, 1'b0);
        issue(16'h8000, 16'h0002, 32'h00010000, 1'b1, 1'b0);
        wait_valid(n);
        @(posedge clk); #1;

        // in_valid held high across three operations
        out_cyc.delete();
        issue(16'h1000, 16'h1000, 32'h01000000, 1'b1, 1'b1);
        acc_c[0] = last_acc;
        issue(16'h00FF, 16'h00FF, 32'h0000FE01, 1'b1, 1'b1);
        acc_c[1] = last_acc;
        issue(16'h0002, 16'h0007, 32'd14, 1'b1, 1'b1);
        acc_c[2] = last_acc;
        in_valid = 1'b0;
        n = 0;
        while (out_cyc.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
        chk("stream_count", 64'(out_cyc.size()), 64'd3);
        chk("accept_gap0", 64'(acc_c[1] - acc_c[0]), 64'd18);
        chk("accept_gap1", 64'(acc_c[2] - acc_c[1]), 64'd18);
        if (out_cyc.size() >= 3) begin
            chk("out_gap0", 64'(out_cyc[1] - out_cyc[0]), 64'd18);
            chk("out_gap1", 64'(out_cyc[2] - out_cyc[1]), 64'd18);
        end
        repeat (40) @(posedge clk);
        #1;
        chk("stream_no_extra", 64'(out_cyc.size()), 64'd3);

`ifdef VEDIC_SIGNED_EN
        op_signed = 1'b1;
        issue(16'hFFFD, 16'h0005, 32'hFFFFFFF1, 1'b1, 1'b0);
        issue(16'h8000, 16'h8000, 32'h40000000, 1'b1, 1'b0);
        op_signed = 1'b0;
        issue(16'hFFFF, 16'h0002, 32'h0001FFFE, 1'b1, 1'b0);
        wait_valid(n);
        @(posedge clk); #1;
`endif

        // Narrow configuration: WIDTH=8, CHUNK=2
        issue8(8'hFF, 8'hFF, 16'hFE01);
        wait_valid8(n);
        chk("latency8", 64'(n), 64'd16);
        issue8(8'h00, 8'h5A, 16'h0000);
        issue8(8'h0F, 8'h10, 16'h00F0);

        n = 0;
        while ((exp_q.size() != 0 || exp8_q.size() != 0) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        chk("drain8", 64'(exp8_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
